// File: rtl/group_rr_scheduler.sv
// Round-robin grant scheduler for bank groups. Each grant tenure lasts until the
// grantee stops requesting or completes burst_limit bursts.
module group_rr_scheduler #(
  parameter int NUM_GROUPS = 4,
  parameter int LIMIT_W    = 8,
  localparam int SEL_W     = $clog2(NUM_GROUPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_GROUPS-1:0] req,
  input  logic [NUM_GROUPS-1:0] done,
  input  logic [LIMIT_W-1:0]    burst_limit,
  output logic [NUM_GROUPS-1:0] start,
  output logic [SEL_W-1:0]      sel,
  output logic                  busy,
  output logic [LIMIT_W-1:0]    burst_cnt,
  output logic                  quota_hit
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [SEL_W-1:0]        last_reg;
  logic [NUM_GROUPS-1:0]   start_reg;
  logic [SEL_W-1:0]        sel_reg;
  logic                    busy_reg;
  logic [LIMIT_W-1:0]      burst_cnt_reg;
  logic                    quota_hit_reg;

  logic                    found;
  logic [SEL_W-1:0]        pick;
  logic                    done_g;
  logic                    req_g;
  logic [LIMIT_W:0]        cnt_plus1;
  logic [LIMIT_W-1:0]      cnt_next;
  logic                    quota_end;
  logic                    tenure_end;
  logic                    do_grant;
  logic                    go_idle;

  function automatic logic [NUM_GROUPS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_GROUPS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan last+1 .. last (wrapping); the first hit wins, so last itself is checked last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_GROUPS; k++) begin
      if (!found && req[(int'(last_reg) + k) % NUM_GROUPS] == 1'b1) begin
        found = 1'b1;
        pick  = SEL_W'((int'(last_reg) + k) % NUM_GROUPS);
      end
    end
  end

  // While granted, last_reg holds the current grantee.
  always_comb begin
    done_g     = done[last_reg];
    req_g      = req[last_reg];
    cnt_plus1  = {1'b0, burst_cnt_reg} + {{LIMIT_W{1'b0}}, 1'b1};
    cnt_next   = burst_cnt_reg;
    if (done_g && !(&burst_cnt_reg)) begin
      cnt_next = cnt_plus1[LIMIT_W-1:0];
    end
    quota_end  = (state_reg == GRANT) && done_g && (burst_limit != '0) &&
                 (cnt_plus1 >= {1'b0, burst_limit});
    tenure_end = (state_reg == GRANT) && (quota_end || !req_g);
    do_grant   = found && ((state_reg == IDLE) || tenure_end);
    go_idle    = !found && tenure_end;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      last_reg      <= SEL_W'(NUM_GROUPS - 1);
      start_reg     <= '0;
      sel_reg       <= '0;
      busy_reg      <= 1'b0;
      burst_cnt_reg <= '0;
      quota_hit_reg <= 1'b0;
    end else begin
      quota_hit_reg <= quota_end;
      if (do_grant) begin
        state_reg     <= GRANT;
        last_reg      <= pick;
        start_reg     <= onehot(pick);
        sel_reg       <= pick;
        busy_reg      <= 1'b1;
        burst_cnt_reg <= '0;
      end else if (go_idle) begin
        state_reg     <= IDLE;
        start_reg     <= '0;
        sel_reg       <= '0;
        busy_reg      <= 1'b0;
        burst_cnt_reg <= '0;
      end else if (state_reg == GRANT) begin
        burst_cnt_reg <= cnt_next;
      end
    end
  end

  assign start     = start_reg;
  assign sel       = sel_reg;
  assign busy      = busy_reg;
  assign burst_cnt = burst_cnt_reg;
  assign quota_hit = quota_hit_reg;

endmodule

// File: tb/tb_group_rr_scheduler.sv
// Bench for group_rr_scheduler: vector table plus hand-written saturation and
// 8-group rotation sequences, checked through an expected-result queue.
module tb_group_rr_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 4-group instance
  logic       rst_n;
  logic [3:0] req, done;
  logic [7:0] burst_limit;
  logic [3:0] start;
  logic [1:0] sel;
  logic       busy;
  logic [7:0] burst_cnt;
  logic       quota_hit;

  group_rr_scheduler #(.NUM_GROUPS(4), .LIMIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .burst_limit(burst_limit),
    .start(start), .sel(sel), .busy(busy), .burst_cnt(burst_cnt), .quota_hit(quota_hit)
  );

  // 8-group instance
  logic       rst8_n;
  logic [7:0] req8, done8;
  logic [7:0] limit8;
  logic [7:0] start8;
  logic [2:0] sel8;
  logic       busy8;
  logic [7:0] cnt8;
  logic       qh8;

  group_rr_scheduler #(.NUM_GROUPS(8), .LIMIT_W(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .req(req8), .done(done8), .burst_limit(limit8),
    .start(start8), .sel(sel8), .busy(busy8), .burst_cnt(cnt8), .quota_hit(qh8)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [7:0] lim;
    logic [3:0] e_start;
    logic [1:0] e_sel;
    logic [7:0] e_cnt;
    logic       e_qh;
  } vec_t;

  typedef struct {
    logic [7:0] e_start;
    logic [2:0] e_sel;
    logic [7:0] e_cnt;
    logic       e_qh;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   row   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                              input logic [7:0] lm, input logic [3:0] es, input logic [1:0] esl,
                              input logic [7:0] ec, input logic eq);
    vec_t v;
    v.rst_n = r; v.req = rq; v.done = dn; v.lim = lm;
    v.e_start = es; v.e_sel = esl; v.e_cnt = ec; v.e_qh = eq;
    return v;
  endfunction

  // Drive one cycle on the 4-group DUT, then compare after the edge.
  task automatic step4(input vec_t v);
    exp_t e;
    rst_n = v.rst_n; req = v.req; done = v.done; burst_limit = v.lim;
    sb.push_back('{e_start: {4'b0, v.e_start}, e_sel: {1'b0, v.e_sel}, e_cnt: v.e_cnt, e_qh: v.e_qh});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("[TB] row %0d rst_n=%b req=%b done=%b lim=%0d -> start=%b sel=%0d cnt=%0d qh=%b",
             row, v.rst_n, v.req, v.done, v.lim, start, sel, burst_cnt, quota_hit);
    check("start", 32'(start), 32'(e.e_start));
    check("sel", 32'(sel), 32'(e.e_sel));
    check("burst_cnt", 32'(burst_cnt), 32'(e.e_cnt));
    check("quota_hit", 32'(quota_hit), 32'(e.e_qh));
    check("busy", 32'(busy), 32'(e.e_start != 8'd0));
    check("onehot", 32'($onehot0(start)), 32'd1);
    row++;
  endtask

  task automatic step8(input logic r, input logic [7:0] rq, input logic [7:0] dn,
                       input logic [7:0] es, input logic [2:0] esl, input logic [7:0] ec, input logic eq);
    exp_t e;
    rst8_n = r; req8 = rq; done8 = dn; limit8 = 8'd1;
    sb.push_back('{e_start: es, e_sel: esl, e_cnt: ec, e_qh: eq});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("[TB] row %0d (8g) req=%b done=%b -> start=%b sel=%0d cnt=%0d qh=%b",
             row, rq, dn, start8, sel8, cnt8, qh8);
    check("start8", 32'(start8), 32'(e.e_start));
    check("sel8", 32'(sel8), 32'(e.e_sel));
    check("cnt8", 32'(cnt8), 32'(e.e_cnt));
    check("qh8", 32'(qh8), 32'(e.e_qh));
    check("busy8", 32'(busy8), 32'(e.e_start != 8'd0));
    row++;
  endtask

  vec_t vecs[32];

  initial begin
    int g;
    rst_n = 1'b0; req = '0; done = '0; burst_limit = '0;
    rst8_n = 1'b0; req8 = '0; done8 = '0; limit8 = 8'd1;

    //          rst req     done    lim  start   sel cnt qh
    vecs[0]  = mk(0, 4'b1111, 4'b0000, 2, 4'b0000, 0, 0, 0); // reset state
    vecs[1]  = mk(1, 4'b1111, 4'b0000, 2, 4'b0001, 0, 0, 0); // group 0 wins first search
    vecs[2]  = mk(1, 4'b1111, 4'b0001, 2, 4'b0001, 0, 1, 0);
    vecs[3]  = mk(1, 4'b1111, 4'b0001, 2, 4'b0010, 1, 0, 1);
    vecs[4]  = mk(1, 4'b1111, 4'b0010, 2, 4'b0010, 1, 1, 0);
    vecs[5]  = mk(1, 4'b1111, 4'b0010, 2, 4'b0100, 2, 0, 1);
    vecs[6]  = mk(1, 4'b1111, 4'b0100, 2, 4'b0100, 2, 1, 0);
    vecs[7]  = mk(1, 4'b1111, 4'b0100, 2, 4'b1000, 3, 0, 1);
    vecs[8]  = mk(1, 4'b1111, 4'b1000, 2, 4'b1000, 3, 1, 0);
    vecs[9]  = mk(1, 4'b1111, 4'b1000, 2, 4'b0001, 0, 0, 1); // wraps to group 0
    vecs[10] = mk(1, 4'b1111, 4'b1110, 2, 4'b0001, 0, 0, 0); // foreign done ignored
    vecs[11] = mk(1, 4'b1111, 4'b0001, 2, 4'b0001, 0, 1, 0);
    vecs[12] = mk(1, 4'b1111, 4'b0001, 2, 4'b0010, 1, 0, 1);
    vecs[13] = mk(1, 4'b1001, 4'b0010, 2, 4'b1000, 3, 0, 0); // req[1] drops with done
    vecs[14] = mk(1, 4'b1001, 4'b1000, 4, 4'b1000, 3, 1, 0);
    vecs[15] = mk(1, 4'b1001, 4'b1000, 4, 4'b1000, 3, 2, 0);
    vecs[16] = mk(1, 4'b1001, 4'b0000, 1, 4'b1000, 3, 2, 0); // limit lowered, no done yet
    vecs[17] = mk(1, 4'b1001, 4'b1000, 1, 4'b0001, 0, 0, 1); // ends at next done
    vecs[18] = mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0); // to IDLE
    vecs[19] = mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
    vecs[20] = mk(1, 4'b0100, 4'b0000, 3, 4'b0100, 2, 0, 0);
    vecs[21] = mk(1, 4'b0100, 4'b0100, 3, 4'b0100, 2, 1, 0);
    vecs[22] = mk(1, 4'b0100, 4'b0100, 3, 4'b0100, 2, 2, 0);
    vecs[23] = mk(1, 4'b0100, 4'b0100, 3, 4'b0100, 2, 0, 1); // self-handoff
    vecs[24] = mk(1, 4'b0100, 4'b0000, 3, 4'b0100, 2, 0, 0);
    vecs[25] = mk(1, 4'b0100, 4'b0100, 0, 4'b0100, 2, 1, 0);
    vecs[26] = mk(1, 4'b0100, 4'b0100, 0, 4'b0100, 2, 2, 0);
    vecs[27] = mk(1, 4'b0100, 4'b0100, 0, 4'b0100, 2, 3, 0);
    vecs[28] = mk(1, 4'b0100, 4'b0100, 0, 4'b0100, 2, 4, 0);
    vecs[29] = mk(1, 4'b0100, 4'b0100, 0, 4'b0100, 2, 5, 0);
    vecs[30] = mk(0, 4'b0100, 4'b0100, 0, 4'b0000, 0, 0, 0); // reset mid-tenure
    vecs[31] = mk(1, 4'b0100, 4'b0000, 0, 4'b0100, 2, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) step4(vecs[i]);

    // Unlimited tenure: counter saturates, grant never moves.
    step4(mk(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0));
    step4(mk(1, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0));
    for (int k = 1; k <= 300; k++)
      step4(mk(1, 4'b0001, 4'b0001, 0, 4'b0001, 0, (k > 255) ? 8'd255 : 8'(k), 0));

    // Eight groups, limit 1: ascending wrap order, one tenure per done.
    step8(0, 8'hFF, 8'h00, 8'h00, 0, 0, 0);
    step8(1, 8'hFF, 8'h00, 8'h01, 0, 0, 0);
    g = 0;
    for (int t = 1; t <= 16; t++) begin
      logic [7:0] dn;
      logic [7:0] es;
      dn = 8'h01 << g;
      g  = (g + 1) % 8;
      es = 8'h01 << g;
      step8(1, 8'hFF, dn, es, 3'(g), 0, 1);
    end

    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
